// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard bundle: decode operands in, stall/forward selects out.
interface hazard_scoreboard_if #(
    parameter int STAGES  = 3,
    parameter int REG_W   = 5,
    parameter int NUM_SRC = 2
);
    localparam int SW = $clog2(STAGES + 1);

    logic                       advance;
    logic                       flush;
    logic                       id_valid;
    logic                       id_wen;
    logic [REG_W-1:0]           id_wsel;
    logic                       id_isload;
    logic [NUM_SRC*REG_W-1:0]   id_src;
    logic [NUM_SRC-1:0]         id_src_used;
    logic                       stall;
    logic [NUM_SRC*SW-1:0]      fwd_sel;
    logic                       busy;

    modport master (
        output advance, flush, id_valid, id_wen, id_wsel,
        output id_isload, id_src, id_src_used,
        input  stall, fwd_sel, busy
    );

    modport slave (
        input  advance, flush, id_valid, id_wen, id_wsel,
        input  id_isload, id_src, id_src_used,
        output stall, fwd_sel, busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Pending-write shift register with decode stall and forward-select logic.
// Forwarding is enabled by defining HAZARD_FORWARD_EN; otherwise any match stalls.
module hazard_scoreboard #(
    parameter int STAGES   = 3,
    parameter int REG_W    = 5,
    parameter int NUM_SRC  = 2,
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 2
) (
    input logic          CLK,
    input logic          nRST,
    hazard_scoreboard_if.slave hz
);
    localparam int SW = $clog2(STAGES + 1);

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    // Index 0 holds entry 1 (EX), index STAGES-1 holds writeback.
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] load_q, load_d;
    logic [REG_W-1:0]  wsel_q [STAGES];
    logic [REG_W-1:0]  wsel_d [STAGES];

    logic [STAGES-1:0]     rdy;
    logic [NUM_SRC-1:0]    stall_vec;
    logic [NUM_SRC*SW-1:0] fwd_c;
    logic [REG_W-1:0]      src;
    logic                  hit;
    logic                  hit_rdy;
    logic [SW-1:0]         hit_idx;
    logic                  stall_c;
    logic                  ins_valid;

    always_comb begin
        rdy = '0;
        for (int k = 0; k < STAGES; k++) begin
            rdy[k] = FWD_ON & (load_q[k] ? (k + 1 >= LOAD_LAT)
                                         : (k + 1 >= ALU_LAT));
        end
    end

    // Descending scan so the youngest (smallest index) match wins.
    always_comb begin
        stall_vec = '0;
        fwd_c     = '0;
        src       = '0;
        hit       = 1'b0;
        hit_rdy   = 1'b0;
        hit_idx   = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            src     = hz.id_src[s*REG_W +: REG_W];
            hit     = 1'b0;
            hit_rdy = 1'b0;
            hit_idx = '0;
            for (int k = STAGES - 1; k >= 0; k--) begin
                if (hz.id_src_used[s] && valid_q[k] &&
                    (wsel_q[k] == src) && (src != '0)) begin
                    hit     = 1'b1;
                    hit_rdy = rdy[k];
                    hit_idx = SW'(k + 1);
                end
            end
            stall_vec[s] = hit & ~hit_rdy;
            if (hit && hit_rdy) begin
                fwd_c[s*SW +: SW] = hit_idx;
            end
        end
    end

    assign stall_c   = hz.id_valid & ~hz.flush & (|stall_vec);
    assign ins_valid = hz.id_valid & hz.id_wen & ~hz.flush & ~stall_c &
                       (hz.id_wsel != '0);

    always_comb begin
        valid_d = valid_q;
        load_d  = load_q;
        wsel_d  = wsel_q;
        if (hz.advance) begin
            valid_d[0] = ins_valid;
            load_d[0]  = hz.id_isload;
            wsel_d[0]  = hz.id_wsel;
            for (int k = 1; k < STAGES; k++) begin
                valid_d[k] = valid_q[k-1];
                load_d[k]  = load_q[k-1];
                wsel_d[k]  = wsel_q[k-1];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
            load_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                wsel_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            load_q  <= load_d;
            for (int k = 0; k < STAGES; k++) begin
                wsel_q[k] <= wsel_d[k];
            end
        end
    end

    assign hz.stall   = stall_c;
    assign hz.fwd_sel = fwd_c;
    assign hz.busy    = |valid_q;
endmodule
